cmd_issuer: RTL and testbench

Host-side initiator for the cache controller. Accepts one request at a time on a valid/ready port, drives the matching `operation_e` command with key and value to the controller, and waits for the controller's `sub_cmd_t` done/error status or a timeout. It then returns a single response on a valid/ready port. It sits between the host-bus adapter and the controller FSM and is the only block that drives controller commands.

---
 rtl/ctrl_types_pkg.sv | 34 +++
 rtl/cmd_timeout_counter.sv | 30 +++
 rtl/cmd_issuer.sv | 138 +++++++++++++
 tb/tb_cmd_issuer.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_types_pkg.sv
// rtl/ctrl_types_pkg.sv - shared controller command, status and issuer types
package ctrl_types_pkg;

   typedef enum logic [2:0] {
      OP_NOOP   = 3'd0,
      OP_READ   = 3'd1,
      OP_CREATE = 3'd2,
      OP_UPDATE = 3'd3,
      OP_DELETE = 3'd4
   } operation_e;

   typedef struct packed {
      logic done;
      logic error;
   } sub_cmd_t;

   typedef enum logic [1:0] {
      IS_IDLE,
      IS_ISSUE,
      IS_WAIT,
      IS_RESP
   } issuer_state_e;

   typedef struct packed {
      logic error;
      logic timeout;
   } issuer_rsp_t;

   // Opcodes that need a controller transaction; 5..7 are illegal.
   function automatic logic is_ctrl_op(input logic [2:0] op);
      return (op == OP_READ) || (op == OP_CREATE) || (op == OP_UPDATE) || (op == OP_DELETE);
   endfunction

endpackage

// File: rtl/cmd_timeout_counter.sv
// rtl/cmd_timeout_counter.sv - saturating WAIT-cycle counter with limit flag
module cmd_timeout_counter #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_limit
);
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);
   localparam logic [CW-1:0] LAST  = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] r_count;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (i_clear) begin
         r_count <= '0;
      end else if (i_enable && (r_count != LIMIT)) begin
         r_count <= r_count + CW'(1);
      end
   end

   // High when an enabled cycle now would bring the count to the limit.
   assign o_limit = (r_count >= LAST);

endmodule

// File: rtl/cmd_issuer.sv
// rtl/cmd_issuer.sv - host request to controller command issuer with timeout
module cmd_issuer
   import ctrl_types_pkg::*;
#(
   parameter int KEY_WIDTH      = 16,
   parameter int VALUE_WIDTH    = 64,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   req_valid_i,
   output logic                   req_ready_o,
   input  logic [2:0]             req_op_i,
   input  logic [KEY_WIDTH-1:0]   req_key_i,
   input  logic [VALUE_WIDTH-1:0] req_value_i,
   output logic                   ctrl_valid_o,
   output logic [2:0]             ctrl_op_o,
   output logic [KEY_WIDTH-1:0]   ctrl_key_o,
   output logic [VALUE_WIDTH-1:0] ctrl_value_o,
   input  logic [1:0]             ctrl_status_i,
   input  logic [VALUE_WIDTH-1:0] ctrl_rdata_i,
   output logic                   rsp_valid_o,
   input  logic                   rsp_ready_i,
   output logic [2:0]             rsp_op_o,
   output logic                   rsp_error_o,
   output logic                   rsp_timeout_o,
   output logic [VALUE_WIDTH-1:0] rsp_data_o
);

   issuer_state_e          r_state;
   logic                   r_req_ready;
   logic                   r_ctrl_valid;
   logic [2:0]             r_ctrl_op;
   logic [2:0]             r_op;
   logic [KEY_WIDTH-1:0]   r_key;
   logic [VALUE_WIDTH-1:0] r_value;
   logic                   r_rsp_valid;
   logic [2:0]             r_rsp_op;
   issuer_rsp_t            r_rsp;
   logic [VALUE_WIDTH-1:0] r_rsp_data;

   sub_cmd_t w_status;
   logic     w_clear;
   logic     w_enable;
   logic     w_limit;

   assign w_status = sub_cmd_t'(ctrl_status_i);
   assign w_clear  = (r_state == IS_IDLE) && req_valid_i;
   assign w_enable = (r_state == IS_WAIT) && !w_status.done && !w_status.error;

   cmd_timeout_counter #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_clear  (w_clear),
      .i_enable (w_enable),
      .o_limit  (w_limit)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state      <= IS_IDLE;
         r_req_ready  <= 1'b1;
         r_ctrl_valid <= 1'b0;
         r_ctrl_op    <= OP_NOOP;
         r_op         <= OP_NOOP;
         r_key        <= '0;
         r_value      <= '0;
         r_rsp_valid  <= 1'b0;
         r_rsp_op     <= OP_NOOP;
         r_rsp        <= '0;
         r_rsp_data   <= '0;
      end else begin
         case (r_state)
            IS_IDLE: begin
               if (req_valid_i) begin
                  r_op        <= req_op_i;
                  r_key       <= req_key_i;
                  r_value     <= req_value_i;
                  r_req_ready <= 1'b0;
                  if (is_ctrl_op(req_op_i)) begin
                     r_state      <= IS_ISSUE;
                     r_ctrl_valid <= 1'b1;
                     r_ctrl_op    <= req_op_i;
                  end else begin
                     // NOOP answers cleanly, illegal opcodes answer with an error.
                     r_state       <= IS_RESP;
                     r_rsp_valid   <= 1'b1;
                     r_rsp_op      <= req_op_i;
                     r_rsp.error   <= (req_op_i != OP_NOOP);
                     r_rsp.timeout <= 1'b0;
                     r_rsp_data    <= '0;
                  end
               end
            end
            IS_ISSUE: begin
               r_ctrl_valid <= 1'b0;
               r_ctrl_op    <= OP_NOOP;
               r_state      <= IS_WAIT;
            end
            IS_WAIT: begin
               if (w_status.error || w_status.done || w_limit) begin
                  r_state       <= IS_RESP;
                  r_rsp_valid   <= 1'b1;
                  r_rsp_op      <= r_op;
                  r_rsp.error   <= w_status.error || !w_status.done;
                  r_rsp.timeout <= !w_status.error && !w_status.done;
                  r_rsp_data    <= (w_status.done && !w_status.error && (r_op == OP_READ))
                                   ? ctrl_rdata_i : '0;
               end
            end
            IS_RESP: begin
               if (rsp_ready_i) begin
                  r_state     <= IS_IDLE;
                  r_rsp_valid <= 1'b0;
                  r_req_ready <= 1'b1;
               end
            end
            default: begin
               r_state <= IS_IDLE;
            end
         endcase
      end
   end

   assign req_ready_o   = r_req_ready;
   assign ctrl_valid_o  = r_ctrl_valid;
   assign ctrl_op_o     = r_ctrl_op;
   assign ctrl_key_o    = r_key;
   assign ctrl_value_o  = r_value;
   assign rsp_valid_o   = r_rsp_valid;
   assign rsp_op_o      = r_rsp_op;
   assign rsp_error_o   = r_rsp.error;
   assign rsp_timeout_o = r_rsp.timeout;
   assign rsp_data_o    = r_rsp_data;

endmodule

// File: tb/tb_cmd_issuer.sv
// tb/tb_cmd_issuer.sv - randomized self-checking bench for cmd_issuer
module tb_cmd_issuer;
   localparam int KW = 16;
   localparam int VW = 64;
   localparam int TO = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          req_valid_i;
   logic          req_ready_o;
   logic [2:0]    req_op_i;
   logic [KW-1:0] req_key_i;
   logic [VW-1:0] req_value_i;
   logic          ctrl_valid_o;
   logic [2:0]    ctrl_op_o;
   logic [KW-1:0] ctrl_key_o;
   logic [VW-1:0] ctrl_value_o;
   logic [1:0]    ctrl_status_i;
   logic [VW-1:0] ctrl_rdata_i;
   logic          rsp_valid_o;
   logic          rsp_ready_i;
   logic [2:0]    rsp_op_o;
   logic          rsp_error_o;
   logic          rsp_timeout_o;
   logic [VW-1:0] rsp_data_o;

   cmd_issuer #(.KEY_WIDTH(KW), .VALUE_WIDTH(VW), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_op_i(req_op_i),
      .req_key_i(req_key_i), .req_value_i(req_value_i),
      .ctrl_valid_o(ctrl_valid_o), .ctrl_op_o(ctrl_op_o), .ctrl_key_o(ctrl_key_o),
      .ctrl_value_o(ctrl_value_o), .ctrl_status_i(ctrl_status_i), .ctrl_rdata_i(ctrl_rdata_i),
      .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_op_o(rsp_op_o),
      .rsp_error_o(rsp_error_o), .rsp_timeout_o(rsp_timeout_o), .rsp_data_o(rsp_data_o)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_err    = 0;

   bit            chk_on = 0;
   logic          e_req_ready, e_ctrl_valid, e_rsp_valid, e_err, e_to;
   logic [2:0]    e_ctrl_op, e_rsp_op;
   bit            chk_kv, chk_rsp;
   logic [KW-1:0] e_key;
   logic [VW-1:0] e_val, e_data;

   int            obs_rc, obs_strobes;
   logic [2:0]    obs_ctrl_op, obs_rsp_op;
   logic [KW-1:0] obs_key;
   logic [VW-1:0] obs_data;
   logic          obs_err, obs_to;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_on) begin
         chk("req_ready", req_ready_o, e_req_ready);
         chk("ctrl_valid", ctrl_valid_o, e_ctrl_valid);
         chk("ctrl_op", ctrl_op_o, e_ctrl_op);
         chk("rsp_valid", rsp_valid_o, e_rsp_valid);
         if (chk_kv) begin
            chk("ctrl_key", ctrl_key_o, e_key);
            chk("ctrl_value", ctrl_value_o, e_val);
         end
         if (chk_rsp) begin
            chk("rsp_op", rsp_op_o, e_rsp_op);
            chk("rsp_error", rsp_error_o, e_err);
            chk("rsp_timeout", rsp_timeout_o, e_to);
            chk("rsp_data", rsp_data_o, e_data);
         end
      end
   end

   task automatic set_idle_exp();
      e_req_ready = 1; e_ctrl_valid = 0; e_ctrl_op = 0; e_rsp_valid = 0;
      chk_kv = 0; chk_rsp = 0;
   endtask

   task automatic set_reset_exp();
      set_idle_exp();
      chk_kv = 1; e_key = '0; e_val = '0;
      chk_rsp = 1; e_rsp_op = 0; e_err = 0; e_to = 0; e_data = '0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         req_valid_i   = 0;
         rsp_ready_i   = 1'($urandom);
         ctrl_status_i = 2'($urandom);
         ctrl_rdata_i  = {$urandom, $urandom};
         set_idle_exp();
         @(posedge clk); #1;
      end
   endtask

   // Controller pulse of 'kind' at cycle s after the handshake (0 = none).
   task automatic run_txn(input logic [2:0] op, input logic [KW-1:0] key, input logic [VW-1:0] val,
                          input int s, input logic [1:0] kind, input logic [VW-1:0] rdata,
                          input int rd, input bit noise);
      logic [1:0]    st [0:63];
      int            rc;
      bit            legal;
      logic          m_err, m_to;
      logic [VW-1:0] m_data;
      legal = (op >= 3'd1) && (op <= 3'd4);
      for (int c = 0; c < 64; c++) st[c] = 2'b00;
      if (noise) begin
         st[0] = 2'($urandom);
         st[1] = 2'($urandom);
      end
      if (s > 0 && s < 64) st[s] = kind;
      rc = 0; m_err = 0; m_to = 0; m_data = '0;
      if (!legal) begin
         rc = 1; m_err = (op != 3'd0);
      end else begin
         for (int c = 2; c <= 1 + TO; c++) begin
            if (rc == 0 && st[c] != 2'b00) begin
               rc = c + 1;
               m_err = st[c][0];
               m_data = (!st[c][0] && op == 3'd1) ? rdata : '0;
            end
         end
         if (rc == 0) begin
            rc = 2 + TO; m_err = 1; m_to = 1;
         end
      end
      if (noise) for (int c = rc; c < 64; c++) if (c != s) st[c] = 2'($urandom);
      obs_rc = -1; obs_strobes = 0; obs_ctrl_op = 0; obs_key = 0;
      obs_data = 0; obs_err = 0; obs_to = 0; obs_rsp_op = 0;
      for (int c = 0; c <= rc + rd; c++) begin
         req_valid_i   = (c == 0) || (noise && $urandom_range(0, 3) == 0);
         req_op_i      = (c == 0) ? op : 3'($urandom);
         req_key_i     = (c == 0) ? key : KW'($urandom);
         req_value_i   = (c == 0) ? val : {$urandom, $urandom};
         rsp_ready_i   = (c == rc + rd) || (c < rc && noise && $urandom_range(0, 1) == 1);
         ctrl_status_i = (c < 64) ? st[c] : 2'b00;
         ctrl_rdata_i  = (c == s) ? rdata : {$urandom, $urandom};
         if (c == 0) begin
            set_idle_exp();
         end else begin
            e_req_ready  = 0;
            e_ctrl_valid = legal && (c == 1);
            e_ctrl_op    = (legal && c == 1) ? op : 3'd0;
            chk_kv       = legal && (c < rc);
            e_key        = key;
            e_val        = val;
            e_rsp_valid  = (c >= rc);
            chk_rsp      = (c >= rc);
            e_rsp_op = op; e_err = m_err; e_to = m_to; e_data = m_data;
         end
         if (ctrl_valid_o) begin
            obs_strobes++; obs_ctrl_op = ctrl_op_o; obs_key = ctrl_key_o;
         end
         if (rsp_valid_o && obs_rc < 0) begin
            obs_rc = c; obs_data = rsp_data_o; obs_err = rsp_error_o;
            obs_to = rsp_timeout_o; obs_rsp_op = rsp_op_o;
         end
         @(posedge clk); #1;
      end
      chk("rsp_cycle", obs_rc, rc);
      chk("strobe_count", obs_strobes, legal ? 1 : 0);
   endtask

   task automatic reset_mid_wait();
      int saw;
      saw = 0;
      for (int c = 0; c <= 6; c++) begin
         req_valid_i   = (c == 0);
         req_op_i      = 3'd1;
         req_key_i     = 16'h1234;
         req_value_i   = 64'h55AA;
         rsp_ready_i   = 1;
         rst_n         = (c != 2);
         ctrl_status_i = (c == 3 || c == 5) ? 2'b10 : 2'b00;
         ctrl_rdata_i  = {$urandom, $urandom};
         if (c == 0) set_idle_exp();
         else if (c <= 2) begin
            e_req_ready = 0; e_ctrl_valid = (c == 1); e_ctrl_op = (c == 1) ? 3'd1 : 3'd0;
            e_rsp_valid = 0; chk_kv = 1; e_key = 16'h1234; e_val = 64'h55AA; chk_rsp = 0;
         end else set_reset_exp();
         if (rsp_valid_o) saw++;
         @(posedge clk); #1;
      end
      rst_n = 1;
      chk("reset_no_rsp", saw, 0);
   endtask

   initial begin
      rst_n = 0; req_valid_i = 0; req_op_i = 0; req_key_i = 0; req_value_i = 0;
      ctrl_status_i = 0; ctrl_rdata_i = 0; rsp_ready_i = 0;
      @(posedge clk); #1;
      set_reset_exp(); chk_on = 1;
      @(posedge clk); #1;
      rst_n = 1;
      @(posedge clk); #1;

      run_txn(3'd1, 16'h0042, 64'h0, 3, 2'b10, 64'hDEADBEEF, 0, 0);
      chk("read_rc", obs_rc, 4);
      chk("read_data", obs_data, 64'hDEADBEEF);
      chk("read_err", obs_err, 0);
      chk("read_op", obs_rsp_op, 3'b001);
      chk("read_ctrl_op", obs_ctrl_op, 3'b001);
      chk("read_ctrl_key", obs_key, 16'h0042);
      idle(1);

      run_txn(3'd3, 16'h0101, 64'h77, 2, 2'b11, 64'hCAFE, 1, 0);
      chk("errpri_err", obs_err, 1);
      chk("errpri_to", obs_to, 0);
      chk("errpri_data", obs_data, 0);

      run_txn(3'd4, 16'h0202, 64'h0, 8, 2'b10, 64'h1111, 3, 0);
      chk("to_rc", obs_rc, 6);
      chk("to_err", obs_err, 1);
      chk("to_flag", obs_to, 1);
      run_txn(3'd1, 16'h0303, 64'h0, 2, 2'b10, 64'h2222, 0, 0);
      chk("after_to_err", obs_err, 0);
      chk("after_to_data", obs_data, 64'h2222);

      run_txn(3'd4, 16'h0404, 64'h0, 5, 2'b10, 64'h3333, 0, 0);
      chk("limit_status_err", obs_err, 0);
      chk("limit_status_to", obs_to, 0);

      run_txn(3'd0, 16'h0505, 64'h9, 0, 2'b00, 64'h0, 0, 0);
      chk("noop_rc", obs_rc, 1);
      chk("noop_err", obs_err, 0);
      run_txn(3'd7, 16'h0606, 64'h9, 2, 2'b10, 64'h0, 0, 0);
      chk("illegal_err", obs_err, 1);
      chk("illegal_to", obs_to, 0);
      chk("illegal_strobes", obs_strobes, 0);

      run_txn(3'd2, 16'h0707, 64'hABCD, 2, 2'b10, 64'h4444, 10, 0);
      chk("bp_data", obs_data, 0);
      idle(1);

      reset_mid_wait();
      idle(2);

      for (int i = 0; i < 40; i++) begin
         logic [2:0] op;
         int s;
         op = ($urandom_range(0, 4) == 0) ? 3'($urandom) : 3'($urandom_range(1, 4));
         s  = ($urandom_range(0, 6) == 0) ? 0 : $urandom_range(1, 8);
         run_txn(op, KW'($urandom), {$urandom, $urandom}, s, 2'($urandom_range(1, 3)),
                 {$urandom, $urandom}, $urandom_range(0, 4), 1);
         idle($urandom_range(0, 2));
      end

      chk_on = 0;
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule
